// File: rtl/calc_exec_seq.sv
// calc_exec_seq -- calculator arithmetic sequencer.
//
// Accepts two packed-BCD operands and an opcode from the keypad controller.
// It converts them to binary, runs one operation, converts the result back to
// packed BCD and presents it to the display driver. Only one operation is in
// flight at a time.
//
// Build option: define CALC_SIGNED_SUB_EN to make a subtraction with A<B return
// the magnitude B-A with neg=1. Without it that case reports err and neg is tied 0.
//
// Ports:
//   CLK_1K      system clock (1 kHz)
//   RSTN        asynchronous active-low reset
//   start       request, sampled only while idle
//   opcode      0=pass A, a=add, b=sub, c=mul, d=div, others invalid
//   num_a/num_b packed-BCD operands, MS digit in the top nibble
//   busy        high from the cycle after acceptance until done
//   done        one-cycle pulse, result/err/neg valid from this cycle
//   num_result  packed-BCD result, held until the next done
//   err         overflow / divide-by-zero / bad digit / bad opcode
//   neg         result is negative (signed-sub build only)
module calc_exec_seq #(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 20
) (
  input  logic                CLK_1K,
  input  logic                RSTN,
  input  logic                start,
  input  logic [3:0]          opcode,
  input  logic [4*DIGITS-1:0] num_a,
  input  logic [4*DIGITS-1:0] num_b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] num_result,
  output logic                err,
  output logic                neg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int PRD_W = 2 * BIN_W;
  localparam int CNT_W = $clog2(BIN_W + DIGITS);

  localparam logic [PRD_W-1:0] MAX_RES   = PRD_W'(10**DIGITS - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(BIN_W - 1);

  localparam logic [3:0] OP_PASS = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'ha;
  localparam logic [3:0] OP_SUB  = 4'hb;
  localparam logic [3:0] OP_MUL  = 4'hc;
  localparam logic [3:0] OP_DIV  = 4'hd;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_CHECK,
    S_TOBCD,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [3:0]         op_q;
  logic [BCD_W-1:0]   a_sh_q, b_sh_q;     // operand digits, shifted out MS first
  logic [BIN_W-1:0]   acc_a_q, acc_b_q;   // binary operands; A doubles as quotient, B as multiplier
  logic [PRD_W-1:0]   mcand_q;            // left-shifting multiplicand
  logic [PRD_W-1:0]   res_q;              // binary result / product accumulator
  logic [BIN_W-1:0]   rem_q;              // division partial remainder
  logic [BIN_W-1:0]   bin_q;              // binary value being shifted into the BCD register
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_run_q;          // error seen during the current operation
  logic               lt_q;               // subtraction had A<B
  logic               busy_q, done_q, err_q;
  logic [BCD_W-1:0]   result_q;
`ifdef CALC_SIGNED_SUB_EN
  logic               neg_q;
`endif

  logic [3:0]         dig_a, dig_b;
  logic               dig_bad;
  logic [BIN_W-1:0]   acc_a_d, acc_b_d;
  logic [BIN_W:0]     div_sh;
  logic               div_ge;
  logic [BIN_W-1:0]   rem_d, quot_d;
  logic [BCD_W-1:0]   bcd_adj, bcd_d;

  // Decimal-to-binary step: acc = acc*10 + digit for both operands at once.
  assign dig_a   = a_sh_q[BCD_W-1 -: 4];
  assign dig_b   = b_sh_q[BCD_W-1 -: 4];
  assign dig_bad = (dig_a > 4'd9) || (dig_b > 4'd9);
  assign acc_a_d = acc_a_q * BIN_W'(10) + BIN_W'(dig_a);
  assign acc_b_d = acc_b_q * BIN_W'(10) + BIN_W'(dig_b);

  // Restoring division step: shift the next dividend bit into the remainder,
  // subtract the divisor when it fits, and shift the outcome into the quotient.
  assign div_sh = {rem_q, acc_a_q[BIN_W-1]};
  assign div_ge = (div_sh >= {1'b0, acc_b_q});
  assign rem_d  = div_ge ? BIN_W'(div_sh - {1'b0, acc_b_q}) : div_sh[BIN_W-1:0];
  assign quot_d = {acc_a_q[BIN_W-2:0], div_ge};

  // Double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = BCD_W'({bcd_adj, bin_q[BIN_W-1]});
  end

  always_ff @(posedge CLK_1K or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      mcand_q   <= '0;
      res_q     <= '0;
      rem_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      err_run_q <= 1'b0;
      lt_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
`ifdef CALC_SIGNED_SUB_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh_q    <= num_a;
            b_sh_q    <= num_b;
            op_q      <= opcode;
            acc_a_q   <= '0;
            acc_b_q   <= '0;
            cnt_q     <= '0;
            err_run_q <= 1'b0;
            lt_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end

        S_LOAD: begin
          acc_a_q <= acc_a_d;
          acc_b_q <= acc_b_d;
          a_sh_q  <= a_sh_q << 4;
          b_sh_q  <= b_sh_q << 4;
          if (dig_bad) err_run_q <= 1'b1;
          if (cnt_q == LOAD_LAST) begin
            // Prime the iterative units with the final operand values.
            cnt_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            mcand_q <= PRD_W'(acc_a_d);
            state_q <= (err_run_q || dig_bad) ? S_DONE : S_EXEC;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_EXEC: begin
          case (op_q)
            OP_PASS: begin
              res_q   <= PRD_W'(acc_a_q);
              state_q <= S_CHECK;
            end
            OP_ADD: begin
              res_q   <= PRD_W'(acc_a_q) + PRD_W'(acc_b_q);
              state_q <= S_CHECK;
            end
            OP_SUB: begin
              if (acc_a_q >= acc_b_q) begin
                res_q <= PRD_W'(acc_a_q - acc_b_q);
              end else begin
                res_q <= PRD_W'(acc_b_q - acc_a_q);
                lt_q  <= 1'b1;
              end
              state_q <= S_CHECK;
            end
            OP_MUL: begin
              if (acc_b_q[0]) res_q <= res_q + mcand_q;
              mcand_q <= mcand_q << 1;
              acc_b_q <= acc_b_q >> 1;
              if (cnt_q == ITER_LAST) begin
                cnt_q   <= '0;
                state_q <= S_CHECK;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            OP_DIV: begin
              if (cnt_q == '0 && acc_b_q == '0) begin
                err_run_q <= 1'b1;
                state_q   <= S_DONE;
              end else begin
                rem_q   <= rem_d;
                acc_a_q <= quot_d;
                if (cnt_q == ITER_LAST) begin
                  cnt_q   <= '0;
                  res_q   <= PRD_W'(quot_d);
                  state_q <= S_CHECK;
                end else begin
                  cnt_q <= cnt_q + 1'b1;
                end
              end
            end
            default: begin
              err_run_q <= 1'b1;
              state_q   <= S_DONE;
            end
          endcase
        end

        S_CHECK: begin
          bin_q <= res_q[BIN_W-1:0];
          bcd_q <= '0;
          cnt_q <= '0;
          if (res_q > MAX_RES) begin
            err_run_q <= 1'b1;
            state_q   <= S_DONE;
          end else if (lt_q) begin
`ifdef CALC_SIGNED_SUB_EN
            state_q <= S_TOBCD;
`else
            err_run_q <= 1'b1;
            state_q   <= S_DONE;
`endif
          end else begin
            state_q <= S_TOBCD;
          end
        end

        S_TOBCD: begin
          bcd_q <= bcd_d;
          bin_q <= bin_q << 1;
          if (cnt_q == ITER_LAST) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          result_q <= err_run_q ? '0 : bcd_q;
          err_q    <= err_run_q;
`ifdef CALC_SIGNED_SUB_EN
          neg_q    <= lt_q && !err_run_q;
`endif
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign num_result = result_q;
  assign err        = err_q;
`ifdef CALC_SIGNED_SUB_EN
  assign neg        = neg_q;
`else
  assign neg        = 1'b0;
`endif

endmodule

// File: tb/tb_calc_exec_seq.sv
// tb_calc_exec_seq -- directed bench for calc_exec_seq (DIGITS=6, BIN_W=20).
// Honours CALC_SIGNED_SUB_EN the same way as the design.
`timescale 1ns/1ps
module tb_calc_exec_seq;

  logic        CLK_1K = 1'b0;
  logic        RSTN   = 1'b0;
  logic        start  = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic [23:0] num_a  = '0;
  logic [23:0] num_b  = '0;
  logic        busy, done, err, neg;
  logic [23:0] num_result;

  calc_exec_seq dut (
    .CLK_1K     (CLK_1K),
    .RSTN       (RSTN),
    .start      (start),
    .opcode     (opcode),
    .num_a      (num_a),
    .num_b      (num_b),
    .busy       (busy),
    .done       (done),
    .num_result (num_result),
    .err        (err),
    .neg        (neg)
  );

  always #5 CLK_1K = ~CLK_1K;

  typedef struct packed {
    int          lat;
    logic [23:0] res;
    logic        err;
    logic        neg;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  int          edge_n = 0;
  int          launch_id = 0;
  int          seen_id = 0;
  int          done_id = 0;
  int          exp_done_edge = 0;
  bit          active = 1'b0;
  bit          lit_lat_on = 1'b0;
  exp_t        cur, lit;
  logic [23:0] held_res = '0;
  logic        held_err = 1'b0;
  logic        held_neg = 1'b0;

  always @(posedge CLK_1K) edge_n <= edge_n + 1;

  // Reference behaviour: plain decimal arithmetic plus the phase lengths
  // (6 load, 1 or 20 execute, 1 check, 20 conversion, 1 done).
  function automatic exp_t model(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
    exp_t   e;
    longint va = 0, vb = 0, r = 0;
    bit     bad_dig = 1'b0;
    int     exec_c = 1;
    e = '0;
    for (int i = 5; i >= 0; i--) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_dig = 1'b1;
      va = va * 10 + longint'(a[4*i +: 4]);
      vb = vb * 10 + longint'(b[4*i +: 4]);
    end
    if (bad_dig) begin
      e.lat = 7; e.err = 1'b1; return e;
    end
    case (op)
      4'h0: r = va;
      4'ha: r = va + vb;
      4'hb: begin
        if (va >= vb) r = va - vb;
        else begin
`ifdef CALC_SIGNED_SUB_EN
          r = vb - va; e.neg = 1'b1;
`else
          e.lat = 6 + 1 + 1 + 1; e.err = 1'b1; return e;
`endif
        end
      end
      4'hc: begin r = va * vb; exec_c = 20; end
      4'hd: begin
        if (vb == 0) begin e.lat = 8; e.err = 1'b1; return e; end
        r = va / vb; exec_c = 20;
      end
      default: begin e.lat = 8; e.err = 1'b1; return e; end
    endcase
    if (r > 999999) begin
      e.lat = 6 + exec_c + 1 + 1; e.err = 1'b1; e.neg = 1'b0; return e;
    end
    e.lat = 6 + exec_c + 1 + 20 + 1;
    for (int i = 0; i < 6; i++) begin
      e.res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp_v, edge_n);
    end
  endtask

  // Compare process: every cycle, outputs against the model's timeline.
  always @(negedge CLK_1K) begin
    if (!RSTN) begin
      active   = 1'b0;
      seen_id  = launch_id;
      done_id  = launch_id;
      held_res = '0;
      held_err = 1'b0;
      held_neg = 1'b0;
    end else if (launch_id != seen_id) begin
      seen_id = launch_id;
      active  = 1'b1;
      if (lit_lat_on) chk("pin_lat", 64'(cur.lat), 64'(lit.lat));
      chk("pin_res", 64'(cur.res), 64'(lit.res));
      chk("pin_err", 64'(cur.err), 64'(lit.err));
      chk("pin_neg", 64'(cur.neg), 64'(lit.neg));
    end
    if (active && edge_n == exp_done_edge) begin
      chk("done", 64'(done), 64'd1);
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("num_result", 64'(num_result), 64'(cur.res));
      chk("err", 64'(err), 64'(cur.err));
      chk("neg", 64'(neg), 64'(cur.neg));
      held_res = cur.res;
      held_err = cur.err;
      held_neg = cur.neg;
      active   = 1'b0;
      done_id  = seen_id;
    end else if (active && edge_n > exp_done_edge) begin
      chk("done_missing", 64'(done), 64'd1);
      active  = 1'b0;
      done_id = seen_id;
    end else begin
      chk("done_idle", 64'(done), 64'd0);
      chk("busy", 64'(busy), 64'(active));
      chk("held_result", 64'(num_result), 64'(held_res));
      chk("held_err", 64'(err), 64'(held_err));
      chk("held_neg", 64'(neg), 64'(held_neg));
    end
  end

  task automatic record(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                        input int llat, input logic [23:0] lres, input logic lerr, input logic lneg);
    cur           = model(op, a, b);
    lit.lat       = llat;
    lit.res       = lres;
    lit.err       = lerr;
    lit.neg       = lneg;
    lit_lat_on    = (llat >= 0);
    exp_done_edge = edge_n + cur.lat;
    launch_id++;
  endtask

  task automatic launch(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                        input int llat, input logic [23:0] lres, input logic lerr,
                        input logic lneg, input bit hold);
    @(negedge CLK_1K); #1;
    opcode = op; num_a = a; num_b = b; start = 1'b1;
    @(posedge CLK_1K); #1;
    record(op, a, b, llat, lres, lerr, lneg);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (done_id != launch_id) begin
      if (n >= 300) begin
        $display("FAIL wait_idle: no completion after %0d cycles", n);
        $fatal(1, "bench stuck");
      end
      @(posedge CLK_1K); #2;
      n++;
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                     input int llat, input logic [23:0] lres, input logic lerr, input logic lneg);
    launch(op, a, b, llat, lres, lerr, lneg, 1'b0);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN = 1'b0;
    repeat (3) @(negedge CLK_1K);
    #1 RSTN = 1'b1;

    run(4'ha, 24'h000123, 24'h000456, 29, 24'h000579, 1'b0, 1'b0);
    run(4'hc, 24'h001000, 24'h001000, 28, 24'h000000, 1'b1, 1'b0);
    run(4'hc, 24'h000999, 24'h001000, 48, 24'h999000, 1'b0, 1'b0);
    run(4'hd, 24'h000007, 24'h000002, 48, 24'h000003, 1'b0, 1'b0);
    run(4'hd, 24'h000100, 24'h000000,  8, 24'h000000, 1'b1, 1'b0);
`ifdef CALC_SIGNED_SUB_EN
    run(4'hb, 24'h000005, 24'h000008, 29, 24'h000003, 1'b0, 1'b1);
`else
    run(4'hb, 24'h000005, 24'h000008, -1, 24'h000000, 1'b1, 1'b0);
`endif
    run(4'ha, 24'h00000A, 24'h000001,  7, 24'h000000, 1'b1, 1'b0);
    run(4'h5, 24'h000001, 24'h000002,  8, 24'h000000, 1'b1, 1'b0);
    run(4'h0, 24'h123456, 24'h000000, 29, 24'h123456, 1'b0, 1'b0);
    run(4'ha, 24'h999999, 24'h000001,  9, 24'h000000, 1'b1, 1'b0);
    run(4'hd, 24'h000000, 24'h000123, 48, 24'h000000, 1'b0, 1'b0);
    run(4'hb, 24'h004567, 24'h004567, 29, 24'h000000, 1'b0, 1'b0);
    run(4'h0, 24'h000000, 24'h000000, 29, 24'h000000, 1'b0, 1'b0);
    run(4'hb, 24'h000500, 24'h000123, 29, 24'h000377, 1'b0, 1'b0);
    run(4'hc, 24'h000123, 24'h000456, 48, 24'h056088, 1'b0, 1'b0);
    run(4'hd, 24'h999999, 24'h000007, 48, 24'h142857, 1'b0, 1'b0);

    // A start pulse three cycles into a multiply must be ignored.
    launch(4'hc, 24'h000999, 24'h001000, 48, 24'h999000, 1'b0, 1'b0, 1'b0);
    @(posedge CLK_1K);
    @(posedge CLK_1K); #1;
    start = 1'b1; opcode = 4'ha; num_a = 24'h000001; num_b = 24'h000001;
    @(posedge CLK_1K); #1;
    start = 1'b0;
    wait_idle();

    // Reset ten cycles into an operation: no done, outputs cleared.
    launch(4'hc, 24'h000999, 24'h001000, 48, 24'h999000, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge CLK_1K);
    #1 RSTN = 1'b0;
    @(negedge CLK_1K);
    @(negedge CLK_1K);
    #1 RSTN = 1'b1;
    wait_idle();
    run(4'ha, 24'h000042, 24'h000058, 29, 24'h000100, 1'b0, 1'b0);

    // start held high relaunches one cycle after done.
    launch(4'ha, 24'h000011, 24'h000022, 29, 24'h000033, 1'b0, 1'b0, 1'b1);
    wait_idle();
    record(4'ha, 24'h000011, 24'h000022, 29, 24'h000033, 1'b0, 1'b0);
    start = 1'b0;
    wait_idle();

    repeat (3) @(negedge CLK_1K);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
